// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-port bundle for fifo_wr_arbiter
// master = arbiter side, slave = requesters + FIFO write port side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 16
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DWIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      fifo_stall_i;
    logic                      fifo_wrreq_o;
    logic [DWIDTH-1:0]         fifo_data_o;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      busy_o;

    modport master (
        input  req_valid_i, req_data_i, fifo_stall_i,
        output req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o, busy_o
    );

    modport slave (
        output req_valid_i, req_data_i, fifo_stall_i,
        input  req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o, busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter onto a single FIFO write port
// Optional per-requester word counters are enabled by defining ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
`ifdef ARB_STATS_EN
    input  logic                         stats_clr_i,
    output logic [NUM_REQ*CNT_WIDTH-1:0] word_cnt_o,
`endif
    fifo_wr_arbiter_if.master            bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    if (NUM_REQ < 2 || MAX_BURST < 1 || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: illegal parameter combination");
    end

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand;
    logic               win_found;
    logic               g_valid;
    logic               xfer;
    logic               burst_end;

    // Rotating priority: scan ptr+1, ptr+2, ... so the last winner goes to the back.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign g_valid = bus.req_valid_i[gidx_q];
    assign xfer    = (state_q == ST_BURST) && g_valid && !bus.fifo_stall_i;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        burst_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BURST;
                    grant_d = NUM_REQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    ptr_d   = win_idx;
                    bcnt_d  = '0;
                end
            end
            ST_BURST: begin
                // A stall leaves everything frozen; only a full burst or a dropped valid ends it.
                burst_end = !g_valid || (xfer && (bcnt_q == BW'(MAX_BURST - 1)));
                if (burst_end) begin
                    if (win_found) begin
                        grant_d = NUM_REQ'(1) << win_idx;
                        gidx_d  = win_idx;
                        ptr_d   = win_idx;
                        bcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        bcnt_d  = '0;
                    end
                end else if (xfer) begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        bus.req_ready_o  = '0;
        bus.fifo_wrreq_o = 1'b0;
        bus.fifo_data_o  = '0;
        if (state_q == ST_BURST) begin
            bus.req_ready_o[gidx_q] = !bus.fifo_stall_i;
            bus.fifo_wrreq_o        = xfer;
            bus.fifo_data_o         = bus.req_data_i[gidx_q*DWIDTH +: DWIDTH];
        end
    end

    assign bus.grant_o = grant_q;
    assign bus.busy_o  = (state_q == ST_BURST);

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (stats_clr_i) begin
                    cnt_q[k] <= '0;
                end else if (xfer && (gidx_q == IW'(k)) && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        word_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) word_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end
`endif
endmodule
